// File: rtl/gpio_serial_loader_if.sv
// gpio_serial_loader_if: start/config fetch/status and serial chain signals of the GPIO loader
//   start                  request to program the chain (master -> slave)
//   cfg_idx / cfg_word     config word fetch; cfg_word is combinational from cfg_idx
//   busy / done            sequence status
//   serial_resetn/clock/data/load  daisy chain drive
interface gpio_serial_loader_if #(
    parameter int IDX_W  = 5,
    parameter int WORD_W = 13
);
    logic              start;
    logic [IDX_W-1:0]  cfg_idx;
    logic [WORD_W-1:0] cfg_word;
    logic              busy;
    logic              done;
    logic              serial_resetn;
    logic              serial_clock;
    logic              serial_data;
    logic              serial_load;
    modport master (
        output start, cfg_word,
        input  cfg_idx, busy, done, serial_resetn, serial_clock, serial_data, serial_load
    );
    modport slave (
        input  start, cfg_word,
        output cfg_idx, busy, done, serial_resetn, serial_clock, serial_data, serial_load
    );
endinterface

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: shifts NUM_GPIO config words MSB first into the GPIO control chain, then strobes load
//   wb_clk_i  system clock, rising edge
//   wb_rst_i  synchronous active-high reset
//   bus       slave side of gpio_serial_loader_if (start, cfg fetch, busy/done, serial chain outputs)
module gpio_serial_loader #(
    parameter int NUM_GPIO = 19,
    parameter int WORD_W   = 13,
    parameter int CLK_DIV  = 2,
    parameter int IDX_W    = 5
) (
    input logic                 wb_clk_i,
    input logic                 wb_rst_i,
    gpio_serial_loader_if.slave bus
);
    localparam int PH_W  = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_GPIO - 1);
    typedef enum logic [2:0] {IDLE, CRST, FETCH, SETUP, HIGH, LOAD, DONE} state_e;
    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic              pend_q, pend_d;
    logic              busy_q, done_q, sclk_q, sload_q, sdata_q, srstn_q;
    logic [IDX_W-1:0]  cfg_idx_q;
    logic              ph_end;
    assign ph_end = phase_q == PH_LAST;
    // A start seen in the DONE cycle is carried through the following IDLE cycle,
    // so a back-to-back request still gets exactly one idle cycle between sequences.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        pend_d  = 1'b0;
        case (state_q)
            IDLE:  if (bus.start || pend_q) state_d = CRST;
            CRST:  if (ph_end) begin
                idx_d   = IDX_LAST;
                state_d = FETCH;
            end
            FETCH: begin
                sr_d    = bus.cfg_word;
                bit_d   = '0;
                state_d = SETUP;
            end
            SETUP: if (ph_end) state_d = HIGH;
            HIGH:  if (ph_end) begin
                sr_d  = sr_q << 1;
                bit_d = bit_q + 1'b1;
                if (bit_q != BIT_LAST) state_d = SETUP;
                else if (idx_q != '0) begin
                    idx_d   = idx_q - 1'b1;
                    state_d = FETCH;
                end else state_d = LOAD;
            end
            LOAD:  if (ph_end) state_d = DONE;
            DONE:  begin
                pend_d  = bus.start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        phase_d = (state_d == state_q && state_q != IDLE) ? phase_q + 1'b1 : '0;
    end
    // Outputs are registered from the next state so each one lines up with the state it belongs to.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            sr_q      <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sload_q   <= 1'b0;
            sdata_q   <= 1'b0;
            srstn_q   <= 1'b0;
            cfg_idx_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            pend_q  <= pend_d;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DONE;
            sclk_q  <= state_d == HIGH;
            sload_q <= state_d == LOAD;
            srstn_q <= state_d != CRST;
            if (state_d == SETUP) sdata_q <= sr_d[WORD_W-1];
            if (state_d == FETCH) cfg_idx_q <= idx_d;
        end
    end
    assign bus.cfg_idx       = cfg_idx_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.serial_clock  = sclk_q;
    assign bus.serial_load   = sload_q;
    assign bus.serial_data   = sdata_q;
    assign bus.serial_resetn = srstn_q;
endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader: directed checks of four loader configurations sharing one clock
module tb_gpio_serial_loader;
    localparam int NG [4] = '{2, 19, 1, 1};
    localparam int DV [4] = '{1, 2, 3, 1};
    logic clk = 1'b0;
    logic [3:0] rst = 4'hF;
    logic [3:0] st = 4'h0;
    logic [12:0] wa [2];
    always #5 clk = ~clk;
    gpio_serial_loader_if #(.IDX_W(5), .WORD_W(13)) ia ();
    gpio_serial_loader_if #(.IDX_W(5), .WORD_W(13)) ib ();
    gpio_serial_loader_if #(.IDX_W(5), .WORD_W(13)) ic ();
    gpio_serial_loader_if #(.IDX_W(5), .WORD_W(13)) ie ();
    gpio_serial_loader #(.NUM_GPIO(2), .CLK_DIV(1)) u_a (.wb_clk_i(clk), .wb_rst_i(rst[0]), .bus(ia));
    gpio_serial_loader u_b (.wb_clk_i(clk), .wb_rst_i(rst[1]), .bus(ib));
    gpio_serial_loader #(.NUM_GPIO(1), .CLK_DIV(3)) u_c (.wb_clk_i(clk), .wb_rst_i(rst[2]), .bus(ic));
    gpio_serial_loader #(.NUM_GPIO(1), .CLK_DIV(1)) u_e (.wb_clk_i(clk), .wb_rst_i(rst[3]), .bus(ie));
    assign ia.start = st[0];
    assign ib.start = st[1];
    assign ic.start = st[2];
    assign ie.start = st[3];
    assign ia.cfg_word = wa[ia.cfg_idx[0]];
    assign ib.cfg_word = 13'h1FFF;
    assign ic.cfg_word = 13'h1555;
    assign ie.cfg_word = 13'h1ABC;
    logic [3:0] sclk, sdat, sld, srn, bsy, dn;
    assign sclk = {ie.serial_clock, ic.serial_clock, ib.serial_clock, ia.serial_clock};
    assign sdat = {ie.serial_data, ic.serial_data, ib.serial_data, ia.serial_data};
    assign sld  = {ie.serial_load, ic.serial_load, ib.serial_load, ia.serial_load};
    assign srn  = {ie.serial_resetn, ic.serial_resetn, ib.serial_resetn, ia.serial_resetn};
    assign bsy  = {ie.busy, ic.busy, ib.busy, ia.busy};
    assign dn   = {ie.done, ic.done, ib.done, ia.done};
    logic [5:0] outs_a;
    assign outs_a = {ia.busy, ia.done, ia.serial_clock, ia.serial_load, ia.serial_data, ia.serial_resetn};
    int edges [4], ones [4], dones [4], ldc [4], viol [4], hir [4], hiruns [4], lor [4], badph [4];
    int rnl [4], blow [4], gaps [4], gapbad [4], seqbad [4], laste [4], seen [4];
    bit [3:0] psclk, psdat;
    bit [63:0] cap [4];
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (sclk[i] && !psclk[i]) begin
                edges[i] <= edges[i] + 1;
                ones[i]  <= ones[i] + int'(sdat[i]);
                cap[i]   <= {cap[i][62:0], sdat[i]};
                if (seen[i] != 0 && lor[i] != DV[i]) badph[i] <= badph[i] + 1;
                seen[i] <= 1;
            end
            if (sclk[i]) begin
                hir[i] <= hir[i] + 1;
                lor[i] <= 0;
            end else begin
                if (hir[i] != 0) begin
                    hiruns[i] <= hiruns[i] + 1;
                    if (hir[i] != DV[i]) badph[i] <= badph[i] + 1;
                end
                hir[i] <= 0;
                lor[i] <= lor[i] + 1;
            end
            if ((sdat[i] != psdat[i] && sclk[i]) || (sld[i] && sclk[i])) viol[i] <= viol[i] + 1;
            if (sld[i]) ldc[i] <= ldc[i] + 1;
            if (!srn[i]) rnl[i] <= rnl[i] + 1;
            if (!bsy[i]) blow[i] <= blow[i] + 1;
            else begin
                if (blow[i] != 0 && dones[i] != 0) begin
                    gaps[i] <= gaps[i] + 1;
                    if (blow[i] != 1) gapbad[i] <= gapbad[i] + 1;
                end
                blow[i] <= 0;
            end
            if (dn[i]) begin
                dones[i] <= dones[i] + 1;
                if (edges[i] - laste[i] != NG[i] * 13) seqbad[i] <= seqbad[i] + 1;
                laste[i] <= edges[i];
                seen[i]  <= 0;
            end
            if (rst[i]) begin
                laste[i] <= edges[i];
                seen[i]  <= 0;
            end
            psclk[i] <= sclk[i];
            psdat[i] <= sdat[i];
        end
    end
    int vectors = 0;
    int miscompares = 0;
    int e_s, o_s, d_s, l_s, r_s, h_s, g_s;
    int n, bl;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic snap(input int i);
        @(posedge clk);
        e_s = edges[i];
        o_s = ones[i];
        d_s = dones[i];
        l_s = ldc[i];
        r_s = rnl[i];
        h_s = hiruns[i];
        g_s = gaps[i];
    endtask
    task automatic run(input int i, input int poke, output int cycles, output int lows);
        @(negedge clk) st[i] = 1'b1;
        @(negedge clk) st[i] = 1'b0;
        cycles = 1;
        lows = bsy[i] ? 0 : 1;
        while (!dn[i] && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            st[i] = cycles == poke;
            if (!bsy[i]) lows++;
        end
        st[i] = 1'b0;
    endtask
    initial begin
        wa[1] = 13'h1803;
        wa[0] = 13'h0402;
        repeat (3) @(negedge clk);
        check("rst_outs", 64'(outs_a), 64'h0);
        check("rst_idx", 64'(ia.cfg_idx), 64'h0);
        rst = 4'h0;
        @(negedge clk);
        check("idle_outs", 64'(outs_a), 64'h01);
        snap(0);
        run(0, 0, n, bl);
        check("a_latency", 64'(n), 64'd57);
        @(posedge clk);
        check("a_bits", cap[0][25:0], 64'({13'h1803, 13'h0402}));
        check("a_edges", 64'(edges[0] - e_s), 64'd26);
        check("a_load_cycles", 64'(ldc[0] - l_s), 64'd1);
        check("a_dones", 64'(dones[0] - d_s), 64'd1);
        snap(0);
        @(negedge clk) st[0] = 1'b1;
        @(negedge clk) st[0] = 1'b0;
        repeat (13) @(negedge clk);
        check("a_mid_high", 64'({ia.serial_clock, ia.cfg_idx}), 64'({1'b1, 5'd1}));
        rst[0] = 1'b1;
        @(negedge clk);
        check("a_abort_outs", 64'(outs_a), 64'h0);
        check("a_abort_idx", 64'(ia.cfg_idx), 64'h0);
        @(negedge clk) rst[0] = 1'b0;
        repeat (70) @(negedge clk);
        @(posedge clk);
        check("a_abort_done", 64'(dones[0] - d_s), 64'd0);
        check("a_abort_load", 64'(ldc[0] - l_s), 64'd0);
        snap(0);
        run(0, 0, n, bl);
        check("a_rerun_latency", 64'(n), 64'd57);
        @(posedge clk);
        check("a_rerun_edges", 64'(edges[0] - e_s), 64'd26);
        snap(0);
        run(0, 20, n, bl);
        check("a_poke_latency", 64'(n), 64'd57);
        repeat (70) @(negedge clk);
        @(posedge clk);
        check("a_poke_edges", 64'(edges[0] - e_s), 64'd26);
        check("a_poke_dones", 64'(dones[0] - d_s), 64'd1);
        snap(0);
        run(0, 0, n, bl);
        st[0] = 1'b1;
        @(negedge clk) st[0] = 1'b0;
        repeat (70) @(negedge clk);
        @(posedge clk);
        check("a_done_start_dones", 64'(dones[0] - d_s), 64'd2);
        check("a_done_start_edges", 64'(edges[0] - e_s), 64'd52);
        check("a_seq_edges", 64'(seqbad[0]), 64'd0);
        check("a_data_timing", 64'(viol[0]), 64'd0);
        snap(1);
        run(1, 0, n, bl);
        check("b_latency", 64'(n), 64'd1012);
        check("b_busy_low", 64'(bl), 64'd0);
        @(posedge clk);
        check("b_edges", 64'(edges[1] - e_s), 64'd247);
        check("b_ones", 64'(ones[1] - o_s), 64'd247);
        check("b_load_cycles", 64'(ldc[1] - l_s), 64'd2);
        check("b_data_timing", 64'(viol[1]), 64'd0);
        check("b_seq_edges", 64'(seqbad[1]), 64'd0);
        snap(2);
        run(2, 0, n, bl);
        check("c_latency", 64'(n), 64'd86);
        @(posedge clk);
        check("c_resetn_low", 64'(rnl[2] - r_s), 64'd3);
        check("c_high_runs", 64'(hiruns[2] - h_s), 64'd13);
        check("c_phase_len", 64'(badph[2]), 64'd0);
        check("c_data_timing", 64'(viol[2]), 64'd0);
        snap(3);
        @(negedge clk) st[3] = 1'b1;
        repeat (100) @(negedge clk);
        st[3] = 1'b0;
        repeat (40) @(negedge clk);
        @(posedge clk);
        check("e_dones", 64'(dones[3] - d_s), 64'd4);
        check("e_edges", 64'(edges[3] - e_s), 64'd52);
        check("e_gaps", 64'(gaps[3] - g_s), 64'd3);
        check("e_gap_len", 64'(gapbad[3]), 64'd0);
        check("e_seq_edges", 64'(seqbad[3]), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gpio_serial_loader.md
Name: gpio_serial_loader

Overview:
Transmitter end of the GPIO configuration shift chain. On a start request it reads one 13-bit configuration word per GPIO from a register array, MSB first. It then shifts all words serially into the daisy-chained GPIO control blocks and pulses a load strobe so every block latches its new word at the same time. It sits in the housekeeping domain, on the opposite end of the chain from the per-pad default/control logic.

Parameters:
NUM_GPIO, 19, number of control blocks in the chain (>=1)
WORD_W, 13, configuration bits per GPIO (matches gpio_defaults width)
CLK_DIV, 2, clock-cycle length of each serial half-phase (>=1)
IDX_W, 5, width of cfg_idx; must satisfy 2**IDX_W >= NUM_GPIO

Ports:
wb_clk_i  input  1  system clock; all logic on the rising edge
wb_rst_i  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to program the chain
cfg_idx  output  IDX_W  index of the config word being fetched
cfg_word  input  WORD_W  word for cfg_idx, combinational from the register array
busy  output  1  high while a load sequence is in progress
done  output  1  one-cycle pulse when the sequence completes
serial_resetn  output  1  chain reset, active-low
serial_clock  output  1  chain shift clock
serial_data  output  1  chain serial data
serial_load  output  1  chain parallel-load strobe

Behaviour:
- Reset (wb_rst_i=1 at an edge) forces: state=IDLE, busy=0, done=0, serial_clock=0, serial_load=0, serial_data=0, serial_resetn=0, cfg_idx=0.
- Reset applies mid-sequence with no completion: no done, no load pulse.
- All outputs are registered.
- FSM states:
  - IDLE: serial_resetn=1, busy=0. If start=1, go to CRST. start while busy is ignored and is not queued.
  - CRST: serial_resetn=0 for CLK_DIV cycles. Set the word index to NUM_GPIO-1, then go to FETCH.
  - FETCH: 1 cycle. cfg_idx=word index. Capture cfg_word into the WORD_W shift register at the end of the cycle. Clear the bit counter, then go to SETUP. serial_clock=0.
  - SETUP: serial_data = shift register MSB, serial_clock=0, held for CLK_DIV cycles. Then go to HIGH.
  - HIGH: serial_clock=1 for CLK_DIV cycles. serial_data stays stable. On exit, shift the register left by 1 and increment the bit counter.
    - If bits remain, go to SETUP.
    - Else if word index > 0, decrement the index and go to FETCH.
    - Else go to LOAD.
  - LOAD: serial_clock=0, serial_load=1 for CLK_DIV cycles. Then go to DONE.
  - DONE: 1 cycle. done=1, serial_load=0. Then go to IDLE.
- busy=1 in every state except IDLE; it rises the cycle after start is sampled.
- Shift order: word NUM_GPIO-1 first, 0 last; within each word, bit WORD_W-1 first. After the shift, chain position 0 (nearest the loader) holds word 0.
- Exactly NUM_GPIO*WORD_W serial_clock rising edges per sequence.
- serial_data changes only while serial_clock=0, giving CLK_DIV cycles of setup and hold around each rising edge.
- serial_load is never high while serial_clock=1.
- Sequence length from the start-sampled edge to the done cycle: CLK_DIV + NUM_GPIO*(1 + 2*CLK_DIV*WORD_W) + CLK_DIV + 1 cycles.
- start asserted in the same cycle as done, or in the IDLE cycle that follows, is accepted normally.
- The phase counter and bit counter wrap only by FSM reload, never free-running.

Test Plan:
- Reset mid-HIGH in bit 5 of word 1 (NUM_GPIO=2, CLK_DIV=1) -> next cycle all outputs at reset values, no done. A new start then runs a full 57-cycle sequence.
- NUM_GPIO=2, CLK_DIV=1, cfg_word[1]=13'h1803, cfg_word[0]=13'h0402 -> bits captured on serial_clock rising edges:
  - first 13: 1,1,0,0,0,0,0,0,0,0,0,1,1
  - last 13: 0,0,1,0,0,0,0,0,0,0,0,1,0
  - then one serial_load high cycle; done 57 cycles after start.
- Default parameters, all words 13'h1FFF -> exactly 247 serial_clock rising edges, serial_data=1 at each edge, serial_load high for 2 cycles after the final edge, busy high throughout.
- start pulsed again mid-sequence -> ignored: edge count unchanged, a single done pulse.
- CLK_DIV=3 -> serial_clock high/low phases exactly 3 cycles each, serial_data transitions only in low phases, serial_resetn low for 3 cycles after start.
- start held high continuously with NUM_GPIO=1, CLK_DIV=1 -> back-to-back sequences. Each has 13 edges and one done pulse, with busy low for exactly one IDLE cycle between sequences.
